// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two valid/ready requesters.
// Optional macro ALU_ARB_OPCHECK_EN rejects illegal select codes with an error response.
module alu_arbiter #(
    parameter int DW = 4,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_rs1,
    input  logic [DW-1:0] req0_rs2,
    input  logic [SW-1:0] req0_sel,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_rs1,
    input  logic [DW-1:0] req1_rs2,
    input  logic [SW-1:0] req1_sel,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_result,
    output logic          rsp0_zero,
    output logic          rsp0_err,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_result,
    output logic          rsp1_zero,
    output logic          rsp1_err,
    output logic [DW-1:0] alu_rs1,
    output logic [DW-1:0] alu_rs2,
    output logic [SW-1:0] alu_sel,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic [DW-1:0] rs1_q, rs1_d;
    logic [DW-1:0] rs2_q, rs2_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [1:0]    valid_q, valid_d;
    logic [1:0]    zero_q, zero_d;
    logic [DW-1:0] result_q [2];
    logic [DW-1:0] result_d [2];

    logic          grant;
    logic          hs;
    logic          owner_rsp_ready;
    logic [DW-1:0] g_rs1, g_rs2;
    logic [SW-1:0] g_sel;

`ifdef ALU_ARB_OPCHECK_EN
    logic [1:0] err_q, err_d;

    function automatic logic sel_legal(input logic [SW-1:0] s);
        case (s)
            SW'(4'h0), SW'(4'h1), SW'(4'h2), SW'(4'h3), SW'(4'h4),
            SW'(4'h6), SW'(4'h7), SW'(4'hA), SW'(4'hD), SW'(4'hE): sel_legal = 1'b1;
            default: sel_legal = 1'b0;
        endcase
    endfunction
`endif

    // On a tie the port other than the last winner is granted; a lone requester always wins.
    always_comb begin
        grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        req0_ready = rst_n & (state_q == IDLE) & req0_valid & ~grant;
        req1_ready = rst_n & (state_q == IDLE) & req1_valid & grant;
        hs = req0_ready | req1_ready;
        g_rs1 = grant ? req1_rs1 : req0_rs1;
        g_rs2 = grant ? req1_rs2 : req0_rs2;
        g_sel = grant ? req1_sel : req0_sel;
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        zero_d   = zero_q;
        result_d = result_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    last_d  = grant;
                    owner_d = grant;
`ifdef ALU_ARB_OPCHECK_EN
                    if (!sel_legal(g_sel)) begin
                        // Illegal code: answer directly, leave the ALU operands untouched.
                        result_d[grant] = '0;
                        zero_d[grant]   = 1'b0;
                        err_d[grant]    = 1'b1;
                        valid_d[grant]  = 1'b1;
                        state_d         = RESP;
                    end else begin
                        rs1_d   = g_rs1;
                        rs2_d   = g_rs2;
                        sel_d   = g_sel;
                        state_d = EXEC;
                    end
`else
                    rs1_d   = g_rs1;
                    rs2_d   = g_rs2;
                    sel_d   = g_sel;
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                result_d[owner_q] = alu_result;
                zero_d[owner_q]   = alu_zero;
                valid_d[owner_q]  = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
                err_d[owner_q]    = 1'b0;
`endif
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    valid_d[owner_q] = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            sel_q       <= '0;
            valid_q     <= '0;
            zero_q      <= '0;
            result_q[0] <= '0;
            result_q[1] <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q       <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            result_q <= result_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign alu_sel     = sel_q;
    assign rsp0_valid  = valid_q[0];
    assign rsp1_valid  = valid_q[1];
    assign rsp0_result = result_q[0];
    assign rsp1_result = result_q[1];
    assign rsp0_zero   = zero_q[0];
    assign rsp1_zero   = zero_q[1];
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp0_err    = err_q[0];
    assign rsp1_err    = err_q[1];
`else
    assign rsp0_err    = 1'b0;
    assign rsp1_err    = 1'b0;
`endif

endmodule
